ahb3lite_sram_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one single-cycle memory port between two masters.
- Typical masters: an AHB3-Lite slave front-end and a DMA/debug port.
- Drives the write/read port signals of a 1r1w RAM wrapper: write address, write enable, byte enables, write data, read enable, read address; read data returns on dout.
- Contains a post-reset clear engine that zero-fills the memory before any requester is granted.

---
 rtl/ahb3lite_sram_arbiter_if.sv | 26 ++
 rtl/ahb3lite_sram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ahb3lite_sram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two request channels in, one-hot grant and
// shared read-return bus out.
interface ahb3lite_sram_arbiter_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 32,
    localparam int BE   = (DBITS + 7) / 8
);
    logic [1:0]            req_i;
    logic [1:0]            we_i;
    logic [1:0][ABITS-1:0] addr_i;
    logic [1:0][BE-1:0]    be_i;
    logic [1:0][DBITS-1:0] wdata_i;
    logic [1:0]            gnt_o;
    logic [1:0]            rvalid_o;
    logic [DBITS-1:0]      rdata_o;

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/ahb3lite_sram_arbiter.sv
// Round-robin arbiter sharing one 1r1w SRAM port between two requesters, with a post-reset zero-fill.
// States: CLEAR | zero-filling memory, no grants;  ARB | round-robin arbitration with burst limit
module ahb3lite_sram_arbiter #(
    parameter int ABITS          = 8,
    parameter int DBITS          = 32,
    parameter int CLEAR_ON_RESET = 1,
    parameter int MAX_BURST      = 4,
    localparam int BE            = (DBITS + 7) / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    ahb3lite_sram_arbiter_if.slave  bus,
    output logic                    busy_o,
    output logic                    mem_we_o,
    output logic [ABITS-1:0]        mem_waddr_o,
    output logic [BE-1:0]           mem_be_o,
    output logic [DBITS-1:0]        mem_din_o,
    output logic                    mem_re_o,
    output logic [ABITS-1:0]        mem_raddr_o,
    input  logic [DBITS-1:0]        mem_dout_i
);

    typedef enum logic {S_CLEAR, S_ARB} state_e;
    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_ARB;

    state_e             state_q, state_d;
    logic [ABITS-1:0]   clr_q, clr_d;
    logic               last_q, last_d;
    logic [7:0]         burst_q, burst_d;
    logic [1:0]         rd_pend_q, rd_pend_d;
    logic               wr_vld_q;
    logic [ABITS-1:0]   wr_addr_q;
    logic [BE-1:0]      wr_be_q;
    logic [DBITS-1:0]   wr_data_q;
    logic [BE-1:0]      byp_be_q, byp_be_d;
    logic [DBITS-1:0]   byp_data_q;

    logic               any_gnt, sel, keep;
    logic [1:0]         gnt_c;
    logic               we_c, re_c;
    logic [ABITS-1:0]   waddr_c, raddr_c;
    logic [BE-1:0]      be_c;
    logic [DBITS-1:0]   din_c;
    logic [DBITS-1:0]   rdata_c;

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        last_d    = last_q;
        burst_d   = burst_q;
        rd_pend_d = '0;
        byp_be_d  = '0;
        any_gnt   = 1'b0;
        sel       = 1'b0;
        keep      = (burst_q != 8'd0) && (burst_q < 8'(MAX_BURST));
        we_c      = 1'b0;
        waddr_c   = clr_q;
        be_c      = '0;
        din_c     = '0;
        re_c      = 1'b0;
        raddr_c   = '0;
        unique case (state_q)
            S_CLEAR: begin
                we_c  = 1'b1;
                be_c  = '1;
                clr_d = clr_q + 1'b1;
                if (clr_q == '1) state_d = S_ARB;
            end
            S_ARB: begin
                unique case (bus.req_i)
                    2'b01:   begin any_gnt = 1'b1; sel = 1'b0; end
                    2'b10:   begin any_gnt = 1'b1; sel = 1'b1; end
                    2'b11:   begin any_gnt = 1'b1; sel = keep ? last_q : ~last_q; end
                    default: any_gnt = 1'b0;
                endcase
                if (any_gnt) begin
                    // burst_q == 0 means the previous cycle was idle, so nobody owns the port
                    if (sel == last_q && burst_q != 8'd0)
                        burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
                    else
                        burst_d = 8'd1;
                    last_d = sel;
                    if (bus.we_i[sel]) begin
                        we_c    = 1'b1;
                        waddr_c = bus.addr_i[sel];
                        be_c    = bus.be_i[sel];
                        din_c   = bus.wdata_i[sel];
                    end else begin
                        re_c           = 1'b1;
                        raddr_c        = bus.addr_i[sel];
                        rd_pend_d[sel] = 1'b1;
                        if (wr_vld_q && wr_addr_q == bus.addr_i[sel]) byp_be_d = wr_be_q;
                    end
                end else begin
                    burst_d = 8'd0;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign gnt_c = any_gnt ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Lanes written in the cycle before a read come from the local copy, never the RAM.
    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < DBITS; i++)
            rdata_c[i] = byp_be_q[i/8] ? byp_data_q[i] : mem_dout_i[i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RST_STATE;
            clr_q      <= '0;
            last_q     <= 1'b1;
            burst_q    <= 8'd0;
            rd_pend_q  <= 2'b00;
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_be_q    <= '0;
            wr_data_q  <= '0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            rd_pend_q  <= rd_pend_d;
            wr_vld_q   <= we_c;
            wr_addr_q  <= waddr_c;
            wr_be_q    <= be_c;
            wr_data_q  <= din_c;
            byp_be_q   <= byp_be_d;
            byp_data_q <= wr_data_q;
        end
    end

    assign busy_o       = rst_i ? (CLEAR_ON_RESET != 0) : (state_q == S_CLEAR);
    assign bus.gnt_o    = rst_i ? 2'b00 : gnt_c;
    assign bus.rvalid_o = rst_i ? 2'b00 : rd_pend_q;
    assign bus.rdata_o  = rdata_c;
    assign mem_we_o     = we_c & ~rst_i;
    assign mem_waddr_o  = waddr_c;
    assign mem_be_o     = be_c;
    assign mem_din_o    = din_c;
    assign mem_re_o     = re_c & ~rst_i;
    assign mem_raddr_o  = raddr_c;

endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// Randomized and directed bench for the SRAM arbiter against a behavioural arbitration/memory model.
module tb_ahb3lite_sram_arbiter;
    localparam int AB   = 4;
    localparam int DB   = 32;
    localparam int BE   = 4;
    localparam int NW   = 16;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_b;
    int   n_vec  = 0;
    int   n_miss = 0;

    ahb3lite_sram_arbiter_if #(.ABITS(AB), .DBITS(DB)) ifa ();
    ahb3lite_sram_arbiter_if #(.ABITS(AB), .DBITS(DB)) ifb ();

    logic          a_busy, a_we, a_re;
    logic [AB-1:0] a_waddr, a_raddr;
    logic [BE-1:0] a_be;
    logic [DB-1:0] a_din, a_dout;
    logic          b_busy, b_we, b_re;
    logic [AB-1:0] b_waddr, b_raddr;
    logic [BE-1:0] b_be;
    logic [DB-1:0] b_din;
    logic [DB-1:0] b_dout = '0;

    ahb3lite_sram_arbiter #(.ABITS(AB), .DBITS(DB), .CLEAR_ON_RESET(1), .MAX_BURST(MAXB)) dut (
        .clk_i(clk), .rst_i(rst), .bus(ifa.slave), .busy_o(a_busy),
        .mem_we_o(a_we), .mem_waddr_o(a_waddr), .mem_be_o(a_be), .mem_din_o(a_din),
        .mem_re_o(a_re), .mem_raddr_o(a_raddr), .mem_dout_i(a_dout));

    ahb3lite_sram_arbiter #(.ABITS(AB), .DBITS(DB), .CLEAR_ON_RESET(0), .MAX_BURST(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .bus(ifb.slave), .busy_o(b_busy),
        .mem_we_o(b_we), .mem_waddr_o(b_waddr), .mem_be_o(b_be), .mem_din_o(b_din),
        .mem_re_o(b_re), .mem_raddr_o(b_raddr), .mem_dout_i(b_dout));

    // RAM with write commit delayed one cycle, so a read right after a write sees stale data.
    logic [DB-1:0] ram [NW];
    logic          pw_v;
    logic [AB-1:0] pw_a;
    logic [BE-1:0] pw_be;
    logic [DB-1:0] pw_d;
    always @(posedge clk) begin
        if (a_re) a_dout <= ram[a_raddr];
        if (rst) begin
            for (int i = 0; i < NW; i++) ram[i] <= $urandom;
            pw_v <= 1'b0;
        end else begin
            if (pw_v)
                for (int b = 0; b < BE; b++)
                    if (pw_be[b]) ram[pw_a][8*b +: 8] <= pw_d[8*b +: 8];
            pw_v  <= a_we;
            pw_a  <= a_waddr;
            pw_be <= a_be;
            pw_d  <= a_din;
        end
    end

    // Behavioural model
    bit            m_clear;
    int            m_clr, m_last, m_run, m_pend;
    logic [DB-1:0] m_pdata;
    logic [DB-1:0] gold [NW];

    logic [1:0]    s_gnt, s_rvalid;
    logic [DB-1:0] s_rdata;
    logic [AB-1:0] s_waddr;
    logic          s_we, s_busy;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [1:0] req);
        if (req == 2'b00) return -1;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        if (m_run > 0 && m_run < MAXB) return m_last;
        return 1 - m_last;
    endfunction

    task automatic step();
        int g;
        int a;
        @(negedge clk);
        s_gnt = ifa.gnt_o; s_rvalid = ifa.rvalid_o; s_rdata = ifa.rdata_o;
        s_waddr = a_waddr; s_we = a_we; s_busy = a_busy;
        g = -1;
        if (rst) begin
            cmp("rst_gnt", ifa.gnt_o, 0);
            cmp("rst_rvalid", ifa.rvalid_o, 0);
            cmp("rst_we", a_we, 0);
            cmp("rst_re", a_re, 0);
            cmp("rst_busy", a_busy, 1);
        end else if (m_clear) begin
            cmp("clr_busy", a_busy, 1);
            cmp("clr_gnt", ifa.gnt_o, 0);
            cmp("clr_rvalid", ifa.rvalid_o, 0);
            cmp("clr_we", a_we, 1);
            cmp("clr_re", a_re, 0);
            cmp("clr_waddr", a_waddr, m_clr);
            cmp("clr_be", a_be, 4'hF);
            cmp("clr_din", a_din, 0);
        end else begin
            cmp("arb_busy", a_busy, 0);
            g = model_grant(ifa.req_i);
            cmp("gnt", ifa.gnt_o, (g < 0) ? 0 : (1 << g));
            if (g >= 0 && ifa.we_i[g]) begin
                cmp("wr_we", a_we, 1);
                cmp("wr_re", a_re, 0);
                cmp("wr_addr", a_waddr, ifa.addr_i[g]);
                cmp("wr_be", a_be, ifa.be_i[g]);
                cmp("wr_din", a_din, ifa.wdata_i[g]);
            end else if (g >= 0) begin
                cmp("rd_re", a_re, 1);
                cmp("rd_we", a_we, 0);
                cmp("rd_addr", a_raddr, ifa.addr_i[g]);
            end else begin
                cmp("idle_we", a_we, 0);
                cmp("idle_re", a_re, 0);
            end
            cmp("rvalid", ifa.rvalid_o, (m_pend < 0) ? 0 : (1 << m_pend));
            if (m_pend >= 0) cmp("rdata", ifa.rdata_o, m_pdata);
        end
        @(posedge clk);
        if (rst) begin
            m_clear = 1'b1; m_clr = 0; m_last = 1; m_run = 0; m_pend = -1;
        end else if (m_clear) begin
            m_clr++;
            if (m_clr == NW) begin
                m_clear = 1'b0;
                for (int i = 0; i < NW; i++) gold[i] = '0;
            end
        end else begin
            m_pend = -1;
            if (g >= 0) begin
                a = int'(ifa.addr_i[g]);
                if (ifa.we_i[g]) begin
                    for (int b = 0; b < BE; b++)
                        if (ifa.be_i[g][b]) gold[a][8*b +: 8] = ifa.wdata_i[g][8*b +: 8];
                end else begin
                    m_pend  = g;
                    m_pdata = gold[a];
                end
                m_run  = (g == m_last && m_run > 0) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                m_last = g;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic drive(input int r, input logic [1:0] req, input logic we,
                         input logic [AB-1:0] addr, input logic [BE-1:0] be, input logic [DB-1:0] d);
        ifa.req_i[r] = req[0]; ifa.we_i[r] = we; ifa.addr_i[r] = addr;
        ifa.be_i[r] = be; ifa.wdata_i[r] = d;
    endtask

    int seq_exp [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int busy_cnt;
    int gi;
    logic [1:0] hold_req;

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        ifa.req_i = '0; ifa.we_i = '0; ifa.addr_i = '0; ifa.be_i = '0; ifa.wdata_i = '0;
        ifb.req_i = '0; ifb.we_i = '0; ifb.addr_i = '0; ifb.be_i = '0; ifb.wdata_i = '0;
        #1;
        step(); step();
        cmp("lit_rst_busy", s_busy, 1);
        cmp("lit_rst_gnt", s_gnt, 0);

        // clear aborted at counter 7
        rst = 1'b0;
        drive(0, 2'b01, 1'b0, 4'd0, 4'hF, '0);
        drive(1, 2'b01, 1'b0, 4'd1, 4'hF, '0);
        for (int i = 0; i < 7; i++) step();
        cmp("lit_clr_addr6", s_waddr, 6);
        rst = 1'b1;
        step();
        cmp("lit_abort_we", s_we, 0);
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < NW; i++) begin
            step();
            if (i == 0) cmp("lit_clr_restart", s_waddr, 0);
            busy_cnt += int'(s_busy);
        end
        cmp("lit_busy_len", busy_cnt, 16);

        // both requesters hold requests: bursts of MAX_BURST
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) cmp("lit_busy_fall", s_busy, 0);
            gi = (s_gnt == 2'b10) ? 1 : (s_gnt == 2'b01 ? 0 : -1);
            cmp("lit_burst_seq", gi, seq_exp[k]);
        end
        drive(0, 2'b00, 1'b0, 4'd0, 4'h0, '0);
        drive(1, 2'b00, 1'b0, 4'd0, 4'h0, '0);
        step();

        // write then read same address via bypass
        drive(0, 2'b01, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        step(); cmp("lit_wr_gnt", s_gnt, 2'b01);
        drive(0, 2'b01, 1'b0, 4'd3, 4'h0, '0);
        step(); cmp("lit_rd_gnt", s_gnt, 2'b01);
        drive(0, 2'b00, 1'b0, 4'd0, 4'h0, '0);
        step();
        cmp("lit_rd_valid", s_rvalid, 2'b01);
        cmp("lit_rd_data", s_rdata, 32'hDEADBEEF);

        // partial write by req1, immediate read by req0
        drive(0, 2'b01, 1'b1, 4'd5, 4'hF, 32'h11223344);
        step();
        drive(0, 2'b00, 1'b0, 4'd0, 4'h0, '0);
        step(); step();
        drive(1, 2'b01, 1'b1, 4'd5, 4'h3, 32'hAABBCCDD);
        step();
        drive(1, 2'b00, 1'b0, 4'd0, 4'h0, '0);
        drive(0, 2'b01, 1'b0, 4'd5, 4'h0, '0);
        step();
        drive(0, 2'b00, 1'b0, 4'd0, 4'h0, '0);
        step();
        cmp("lit_raw_valid", s_rvalid, 2'b01);
        cmp("lit_raw_data", s_rdata, 32'h1122CCDD);

        // reset with a read outstanding
        drive(0, 2'b01, 1'b0, 4'd3, 4'h0, '0);
        step();
        drive(0, 2'b00, 1'b0, 4'd0, 4'h0, '0);
        rst = 1'b1;
        step(); cmp("lit_abort_rvalid", s_rvalid, 0);
        rst = 1'b0;
        step();
        cmp("lit_post_rst_rvalid", s_rvalid, 0);
        cmp("lit_post_rst_busy", s_busy, 1);
        for (int i = 1; i < NW; i++) step();

        // randomized traffic
        hold_req = 2'b00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) hold_req = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++)
                drive(r, {1'b0, hold_req[r]}, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(1, 15)), 32'($urandom));
            step();
        end

        // MAX_BURST = 1: strict alternation, req0 reads addr 1, req1 writes addr 2
        ifb.req_i = 2'b11; ifb.we_i = 2'b10;
        ifb.addr_i[0] = 4'd1; ifb.addr_i[1] = 4'd2;
        ifb.be_i[1] = 4'hF; ifb.wdata_i[1] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cmp("b_busy", b_busy, 0);
            cmp("b_gnt", ifb.gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            cmp("b_rvalid", ifb.rvalid_o, (k % 2 == 1) ? 2'b01 : 2'b00);
            if (k % 2 == 1) begin
                cmp("b_rdata", ifb.rdata_o, 0);
                cmp("b_we", b_we, 1);
                cmp("b_waddr", b_waddr, 2);
                cmp("b_be", b_be, 4'hF);
                cmp("b_din", b_din, 32'hCAFEF00D);
            end else begin
                cmp("b_re", b_re, 1);
                cmp("b_raddr", b_raddr, 1);
            end
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
